tmr_datapath: RTL
=================

# tmr_datapath

Parametrised successor of the stopwatch datapath: a 100 Hz-resolution time-of-run counter (centiseconds, seconds, minutes, hours) that counts either up (stopwatch) or down (countdown timer). It adds a preset load, a lap-capture register and an expiry flag. It sits between the UART/button control FSM and the display formatter of the dual-watch design, and replaces the up-only datapath when timer mode is required.

## Interface
- `DIV_TICK`, 1_000_000: system clocks per centisecond tick (100 MHz → 100 Hz); the bench uses 4.
- `HOUR_MAX`, 24: hour field modulus (2..32).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clr`  in  1  synchronous clear of divider, time and lap registers.
- `run`  in  1  level; enables divider and counting.
- `mode`  in  1  0 = count up, 1 = count down; sampled every tick.
- `load`  in  1  one-cycle pulse; presets time from `ld_*` and zeroes the divider.
- `ld_msec`/`ld_sec`/`ld_min`/`ld_hour`  in  7/6/6/5  preset values.
- `lap`  in  1  one-cycle pulse; captures the current time.
- `msec`/`sec`/`min`/`hour`  out  7/6/6/5  live time.
- `lap_msec`/`lap_sec`/`lap_min`/`lap_hour`  out  7/6/6/5  captured time.
- `lap_valid`  out  1  level; a lap has been captured since the last clr/rst.
- `wrap`  out  1  one-cycle pulse; up-count rolled over from (HOUR_MAX-1):59:59.99 to 0.
- `expired`  out  1  level; down-count has reached 00:00:00.00.

## Operation
- Reset values: every output is 0, and the divider is 0.
- Priority each cycle: rst > clr > load > tick. `lap` is independent of all of these except rst/clr.
- Divider: counts 0..DIV_TICK-1 while `run`=1 and holds its value while `run`=0. `tick` = (`run` && divider==DIV_TICK-1).
- Up mode, on tick:
  - msec increments mod 100.
  - Each carry ripples in the same cycle through sec (mod 60), min (mod 60) and hour (mod HOUR_MAX).
  - A full rollover pulses `wrap`.
- Down mode, on tick:
  - msec decrements, with a borrow chain in the same cycle.
  - At all-zero, a tick does nothing: no underflow and no wrap.
  - `expired` sets in the same edge the fields become all-zero. It stays set while the time is zero and `mode`=1, and clears on load, clr, rst, or `mode`=0.
  - Loading all-zero in down mode sets `expired` on the next edge.
- Load: each `ld_*` field at or above its modulus saturates to modulus-1, e.g. ld_sec=63 loads 59. The divider restarts at 0, so the next tick comes DIV_TICK `run` cycles later.
- Lap: captures the register values present in the cycle `lap` is high (pre-tick values if a tick occurs in the same cycle) and sets `lap_valid`.
  - Lap together with clr: clr wins, and the lap registers are zero.
  - Lap together with load: the pre-load value is captured.
- Mode change mid-run takes effect on the next tick; the divider is not reset.
- rst or clr mid-count zeroes everything on that edge.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- From clr with `run` held high, the first msec change is visible DIV_TICK cycles later, then every DIV_TICK cycles.
- Load and lap results are visible one cycle after the pulse.
- `wrap` is high for exactly the one cycle in which the fields read zero after rollover.
- `run` deassertion freezes the divider and fields on the next edge; reassertion resumes from the frozen divider count.

## Structure
- Package `tmr_pkg`:
  - field width localparams (7/6/6/5);
  - moduli constants (100, 60, 60);
  - `MODE_UP`/`MODE_DN` constants.
- Sub-module `tmr_field` (parameters MOD, W):
  - inputs: `en`, `dn`, `load`, `ld_val`, plus `clk`/`rst`/`clr`;
  - `carry_out` is combinational, high when `en` and the field is at MOD-1 (up) or 0 (down).
  - Instantiated four times and chained by `carry_out` → `en`.
- The top level holds the divider, saturation logic, zero-detect/expired logic and lap registers.

## Test plan
All cases use DIV_TICK=4 and HOUR_MAX=24.
- Reset, then `run`=1, `mode`=0 for 400 cycles → msec=99 at cycle 399, then sec=1, msec=0 at cycle 400, with `wrap`=0 throughout.
- Load 23:59:59.99 in up mode, then run 4 cycles → all fields 0 and `wrap` pulses exactly 1 cycle.
- Load 00:00:01.00, `mode`=1, run → 00:00:00.99 after 4 cycles; `expired` rises at cycle 400 and the fields stay 0 for another 40 cycles.
- `lap` pulsed in the same cycle as a tick at 00:00:00.05 → lap_msec=5, msec=6, `lap_valid`=1. A later `clr` zeroes both and drops `lap_valid`.
- Load ld_sec=63, ld_msec=120, ld_min=70, ld_hour=31 → sec=59, msec=99, min=59, hour=23.
- `rst` asserted mid-count with `load` and `lap` also high → all outputs 0 on the next edge.

Source files
------------

// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_pkg
// Description : Shared constants for the up/down time-of-run datapath.
//               Holds the field widths and moduli, the mode encoding and a
//               preset saturation helper.
// Revision    : 1.0  initial release
// ============================================================================
package tmr_pkg;

    // Field widths: centiseconds / seconds / minutes / hours
    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Field moduli (the hour modulus is a parameter of the top level)
    localparam int MSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;

    // Count direction encoding on the mode input
    localparam logic MODE_UP = 1'b0;
    localparam logic MODE_DN = 1'b1;

    // Clamp a preset value into the legal range 0..modulus-1
    function automatic int sat_field(input int val, input int modulus);
        return (val >= modulus) ? (modulus - 1) : val;
    endfunction

endpackage : tmr_pkg
`default_nettype wire

// File: rtl/tmr_field.sv
`default_nettype none
// ============================================================================
// Module      : tmr_field
// Description : One modulo-MOD time field that can count up or down, with a
//               synchronous preset. Fields are chained through carry_out/en
//               so a carry or borrow ripples through the whole time in one
//               cycle.
// Ports       : clk, rst, clr  - clock, synchronous reset, synchronous clear
//               en             - count this cycle
//               dn             - 1 = decrement, 0 = increment
//               load, ld_val   - preset (already saturated by the caller)
//               value          - registered field value
//               carry_out      - combinational carry (up) / borrow (down)
// Revision    : 1.0  initial release
// ============================================================================
module tmr_field #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         dn,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] value,
    output logic         carry_out
);

    localparam logic [W-1:0] C_MAX = W'(MOD - 1);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= ld_val;
        end else if (en) begin
            if (dn) begin
                r_value <= (r_value == '0) ? C_MAX : (r_value - 1'b1);
            end else begin
                r_value <= (r_value == C_MAX) ? '0 : (r_value + 1'b1);
            end
        end
    end

    // Next field moves when this one rolls over (up) or borrows (down)
    assign carry_out = en && (dn ? (r_value == '0) : (r_value == C_MAX));
    assign value     = r_value;

endmodule : tmr_field
`default_nettype wire

// File: rtl/tmr_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tmr_datapath
// Description : Centisecond-resolution stopwatch / countdown datapath.
//               A clock divider produces a 100 Hz tick; four chained fields
//               hold cc/ss/mm/hh. Adds preset load with saturation, a lap
//               capture register, an up-count wrap pulse and a down-count
//               expired flag. Every output is registered.
// Ports       : clk, rst, clr        - clock, sync reset, sync clear
//               run, mode            - enable, 0 = up / 1 = down
//               load, ld_*           - preset pulse and preset values
//               lap                  - lap capture pulse
//               msec/sec/min/hour    - live time
//               lap_*, lap_valid     - captured time and its valid flag
//               wrap                 - one-cycle up-count rollover pulse
//               expired              - down-count reached zero
// Revision    : 1.0  initial release
// ============================================================================
module tmr_datapath
    import tmr_pkg::*;
#(
    parameter int DIV_TICK = 1_000_000,
    parameter int HOUR_MAX = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              run,
    input  logic              mode,
    input  logic              load,
    input  logic [MSEC_W-1:0] ld_msec,
    input  logic [SEC_W-1:0]  ld_sec,
    input  logic [MIN_W-1:0]  ld_min,
    input  logic [HOUR_W-1:0] ld_hour,
    input  logic              lap,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [MSEC_W-1:0] lap_msec,
    output logic [SEC_W-1:0]  lap_sec,
    output logic [MIN_W-1:0]  lap_min,
    output logic [HOUR_W-1:0] lap_hour,
    output logic              lap_valid,
    output logic              wrap,
    output logic              expired
);

    localparam int               DIV_W    = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV_TICK - 1);

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    assign w_tick = run && (r_div == C_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_div <= '0;
        end else if (load) begin
            r_div <= '0;
        end else if (run) begin
            r_div <= w_tick ? '0 : (r_div + 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Preset saturation
    // ------------------------------------------------------------------
    logic [MSEC_W-1:0] w_ld_msec;
    logic [SEC_W-1:0]  w_ld_sec;
    logic [MIN_W-1:0]  w_ld_min;
    logic [HOUR_W-1:0] w_ld_hour;

    assign w_ld_msec = MSEC_W'(sat_field(int'(ld_msec), MSEC_MOD));
    assign w_ld_sec  = SEC_W'(sat_field(int'(ld_sec), SEC_MOD));
    assign w_ld_min  = MIN_W'(sat_field(int'(ld_min), MIN_MOD));
    assign w_ld_hour = HOUR_W'(sat_field(int'(ld_hour), HOUR_MAX));

    // ------------------------------------------------------------------
    // Field chain
    // ------------------------------------------------------------------
    logic w_dn;
    logic w_all_zero;
    logic w_msec_en;
    logic w_msec_carry;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_hour_carry;

    assign w_dn       = (mode == MODE_DN);
    assign w_all_zero = (msec == '0) && (sec == '0) && (min == '0) && (hour == '0);

    // A down-count parked at zero ignores ticks instead of borrowing
    assign w_msec_en  = w_tick && !(w_dn && w_all_zero);

    tmr_field #(.MOD(MSEC_MOD), .W(MSEC_W)) u_msec (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (w_msec_en),
        .dn        (w_dn),
        .load      (load),
        .ld_val    (w_ld_msec),
        .value     (msec),
        .carry_out (w_msec_carry)
    );

    tmr_field #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (w_msec_carry),
        .dn        (w_dn),
        .load      (load),
        .ld_val    (w_ld_sec),
        .value     (sec),
        .carry_out (w_sec_carry)
    );

    tmr_field #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (w_sec_carry),
        .dn        (w_dn),
        .load      (load),
        .ld_val    (w_ld_min),
        .value     (min),
        .carry_out (w_min_carry)
    );

    tmr_field #(.MOD(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (w_min_carry),
        .dn        (w_dn),
        .load      (load),
        .ld_val    (w_ld_hour),
        .value     (hour),
        .carry_out (w_hour_carry)
    );

    // ------------------------------------------------------------------
    // Wrap and expired flags
    // ------------------------------------------------------------------
    logic w_tick_to_zero;
    logic r_wrap;
    logic r_expired;

    // Down tick that takes 00:00:00.01 to zero; lets expired rise on the
    // same edge the fields reach zero rather than one cycle later.
    assign w_tick_to_zero = w_msec_en && w_dn && (msec == MSEC_W'(1)) &&
                            (sec == '0) && (min == '0) && (hour == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wrap    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            // Hour carry in up mode only exists on a full rollover
            r_wrap    <= !load && !w_dn && w_hour_carry;
            r_expired <= !load && w_dn && (w_all_zero || w_tick_to_zero);
        end
    end

    assign wrap    = r_wrap;
    assign expired = r_expired;

    // ------------------------------------------------------------------
    // Lap capture: samples the pre-edge field values
    // ------------------------------------------------------------------
    logic [MSEC_W-1:0] r_lap_msec;
    logic [SEC_W-1:0]  r_lap_sec;
    logic [MIN_W-1:0]  r_lap_min;
    logic [HOUR_W-1:0] r_lap_hour;
    logic              r_lap_valid;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_lap_msec  <= '0;
            r_lap_sec   <= '0;
            r_lap_min   <= '0;
            r_lap_hour  <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap) begin
            r_lap_msec  <= msec;
            r_lap_sec   <= sec;
            r_lap_min   <= min;
            r_lap_hour  <= hour;
            r_lap_valid <= 1'b1;
        end
    end

    assign lap_msec  = r_lap_msec;
    assign lap_sec   = r_lap_sec;
    assign lap_min   = r_lap_min;
    assign lap_hour  = r_lap_hour;
    assign lap_valid = r_lap_valid;

endmodule : tmr_datapath
`default_nettype wire
